// File: rtl/graphics_pkg.sv
// Shared types and constants for the block-draw controller.
// CLR_* states exist only when GRAPHICS_CLEAR_EN is defined.
package graphics_pkg;

  localparam int unsigned COORD_W         = 8;
  localparam int unsigned COLOUR_W        = 3;
  localparam int unsigned BLOCK_DIM       = 8;
  localparam int unsigned BLOCK_PIXELS    = 64;
  localparam int unsigned SCREEN_BLOCKS_X = 20;
  localparam int unsigned SCREEN_BLOCKS_Y = 15;
  localparam logic [COLOUR_W-1:0] CLEAR_COLOUR = 3'b000;
  localparam logic [COLOUR_W-1:0] FLASH_COLOUR = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_HOLD,
`ifdef GRAPHICS_CLEAR_EN
    S_CLR_LOAD,
    S_CLR_DRAW,
`endif
    S_DONE
  } state_t;

endpackage

// File: rtl/graphics_control_if.sv
// Request and datapath-strobe bundle between upstream, controller and datapath.
interface graphics_control_if;
  import graphics_pkg::*;

  logic                req_valid;
  logic [COORD_W-1:0]  req_x;
  logic [COORD_W-1:0]  req_y;
  logic [COLOUR_W-1:0] req_colour;
  logic                req_flash;
  logic                req_ready;
  logic                clear_req;
  logic [COORD_W-1:0]  x_out;
  logic [COORD_W-1:0]  y_out;
  logic [COLOUR_W-1:0] colour_out;
  logic                load;
  logic                enable;
  logic                flash;
  logic                plot;
  logic                done;

  modport master (
    output req_valid, req_x, req_y, req_colour, req_flash, clear_req,
    input  req_ready, x_out, y_out, colour_out, load, enable, flash, plot, done
  );

  modport slave (
    input  req_valid, req_x, req_y, req_colour, req_flash, clear_req,
    output req_ready, x_out, y_out, colour_out, load, enable, flash, plot, done
  );

endinterface

// File: rtl/graphics_cycle_timer.sv
// Loadable down-counter; zero_c flags terminal count. Shared by DRAW and HOLD.
module graphics_cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero_c
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/graphics_control.sv
// Block-draw sequencer for graphics_datapath: LOAD, 64-cycle DRAW, optional flash HOLD pass.
// Define GRAPHICS_CLEAR_EN to add the full-screen clear sweep on clear_req.
module graphics_control #(
  parameter int unsigned FLASH_HOLD = 25_000_000
) (
  input  logic              clock,
  input  logic              reset,
  graphics_control_if.slave bus
);
  import graphics_pkg::*;

  localparam int unsigned HOLD_MAX = (FLASH_HOLD > BLOCK_PIXELS) ? FLASH_HOLD : BLOCK_PIXELS;
  localparam int unsigned TIMER_W  = $clog2(HOLD_MAX);
  localparam logic [TIMER_W-1:0] DRAW_LOAD = TIMER_W'(BLOCK_PIXELS - 1);
  localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(FLASH_HOLD - 1);

  state_t              state, next_state;
  logic                flash_pass, flash_pass_next;
  logic                accept;
  logic                timer_load, timer_zero_c;
  logic [TIMER_W-1:0]  timer_value;
  logic                ready_next, load_next, enable_next, flash_next, plot_next, done_next;

  graphics_cycle_timer #(.WIDTH(TIMER_W)) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero_c     (timer_zero_c)
  );

`ifdef GRAPHICS_CLEAR_EN
  localparam int unsigned COL_W = $clog2(SCREEN_BLOCKS_X);
  localparam int unsigned ROW_W = $clog2(SCREEN_BLOCKS_Y);

  logic [COL_W-1:0] col, col_next;
  logic [ROW_W-1:0] row, row_next;
  logic             clear_accept, block_advance, last_block_c;

  assign last_block_c = (col == COL_W'(SCREEN_BLOCKS_X - 1)) && (row == ROW_W'(SCREEN_BLOCKS_Y - 1));

  // Column advances first; wrap to the next row of blocks.
  always_comb begin
    col_next = col + COL_W'(1);
    row_next = row;
    if (col == COL_W'(SCREEN_BLOCKS_X - 1)) begin
      col_next = '0;
      row_next = row + ROW_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear_accept) begin
      col <= '0;
      row <= '0;
    end else if (block_advance) begin
      col <= col_next;
      row <= row_next;
    end
  end
`else
  logic unused_clear;
  assign unused_clear = bus.clear_req;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state, timer control, and next values of the registered strobes.
  always_comb begin
    next_state      = state;
    accept          = 1'b0;
    timer_load      = 1'b0;
    timer_value     = DRAW_LOAD;
    flash_pass_next = flash_pass;
`ifdef GRAPHICS_CLEAR_EN
    clear_accept    = 1'b0;
    block_advance   = 1'b0;
`endif

    case (state)
      S_IDLE: begin
`ifdef GRAPHICS_CLEAR_EN
        if (bus.clear_req) begin
          clear_accept    = 1'b1;
          flash_pass_next = 1'b0;
          next_state      = S_CLR_LOAD;
        end else
`endif
        if (bus.req_valid) begin
          accept          = 1'b1;
          flash_pass_next = bus.req_flash;
          next_state      = S_LOAD;
        end
      end
      S_LOAD: begin
        timer_load = 1'b1;
        next_state = S_DRAW;
      end
      S_DRAW: begin
        if (timer_zero_c) begin
          if (flash_pass) begin
            timer_load  = 1'b1;
            timer_value = HOLD_LOAD;
            next_state  = S_HOLD;
          end else begin
            next_state = S_DONE;
          end
        end
      end
      S_HOLD: begin
        if (timer_zero_c) begin
          flash_pass_next = 1'b0;
          next_state      = S_LOAD;
        end
      end
`ifdef GRAPHICS_CLEAR_EN
      S_CLR_LOAD: begin
        timer_load = 1'b1;
        next_state = S_CLR_DRAW;
      end
      S_CLR_DRAW: begin
        if (timer_zero_c) begin
          if (last_block_c) begin
            next_state = S_DONE;
          end else begin
            block_advance = 1'b1;
            next_state    = S_CLR_LOAD;
          end
        end
      end
`endif
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase

    ready_next  = (next_state == S_IDLE);
    done_next   = (next_state == S_DONE);
    load_next   = (next_state == S_LOAD);
    plot_next   = (next_state == S_DRAW);
    enable_next = (next_state == S_LOAD) || (next_state == S_DRAW);
    flash_next  = flash_pass_next && enable_next;
`ifdef GRAPHICS_CLEAR_EN
    load_next   = load_next   || (next_state == S_CLR_LOAD);
    plot_next   = plot_next   || (next_state == S_CLR_DRAW);
    enable_next = enable_next || (next_state == S_CLR_LOAD) || (next_state == S_CLR_DRAW);
`endif
  end

  // Registered strobes and request fields held steady for the whole request.
  always_ff @(posedge clock) begin
    if (reset) begin
      flash_pass     <= 1'b0;
      bus.req_ready  <= 1'b1;
      bus.load       <= 1'b0;
      bus.enable     <= 1'b0;
      bus.flash      <= 1'b0;
      bus.plot       <= 1'b0;
      bus.done       <= 1'b0;
      bus.x_out      <= '0;
      bus.y_out      <= '0;
      bus.colour_out <= '0;
    end else begin
      flash_pass     <= flash_pass_next;
      bus.req_ready  <= ready_next;
      bus.load       <= load_next;
      bus.enable     <= enable_next;
      bus.flash      <= flash_next;
      bus.plot       <= plot_next;
      bus.done       <= done_next;
      if (accept) begin
        bus.x_out      <= bus.req_x;
        bus.y_out      <= bus.req_y;
        bus.colour_out <= bus.req_colour;
      end
`ifdef GRAPHICS_CLEAR_EN
      else if (clear_accept) begin
        bus.x_out      <= '0;
        bus.y_out      <= '0;
        bus.colour_out <= CLEAR_COLOUR;
      end else if (block_advance) begin
        bus.x_out <= COORD_W'(int'(col_next) * BLOCK_DIM);
        bus.y_out <= COORD_W'(int'(row_next) * BLOCK_DIM);
      end
`endif
    end
  end

endmodule
